aes_job_scheduler: RTL and testbench
====================================

Name: aes_job_scheduler

Overview:
- Two-requester job scheduler for the pipelined AES-256 core.
- Accepts encrypt/decrypt job descriptors, arbitrates round-robin, and holds the core in reset between jobs; the core only re-arms from reset.
- Drives the core's start code and length, then waits for done=3'b111 under a watchdog.
- Returns a per-requester completion or error response. Sits between the software-facing register/queue logic and the AES core.

Parameters:
- N_REQ, 2, number of requesters (fixed at 2 in this revision).
- MAX_LEN, 9'd256, largest legal job length in 32-bit words.
- CLR_CYCLES, 2, minimum core_rst_n low time before launch, in clk cycles.
- TIMEOUT_CYCLES, 4096, watchdog limit in RUN; counter width is $clog2(TIMEOUT_CYCLES)+1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  job request per requester, held until req_ready
- req_mode  in  2  per-requester mode: 0=encrypt, 1=decrypt
- req_len  in  18  per-requester length; [8:0]=req0, [17:9]=req1
- req_ready  out  2  one-cycle grant/accept pulse
- resp_valid  out  2  one-cycle completion pulse to the owning requester
- resp_err  out  1  qualifies resp_valid: 1=rejected or timed out
- busy  out  1  high from accept until the response cycle inclusive
- job_count  out  16  count of successfully completed jobs, wraps at 16'hFFFF->0
- core_rst_n  out  1  active-low reset to the AES core
- core_start  out  2  core start code: 0=idle, 1=encrypt, 2=decrypt
- core_length  out  9  length presented to the core
- core_done  in  3  core status; 3'b111 means the job is finished

Behaviour:
- Reset values, applied asynchronously on reset=1:
  - core_rst_n=0, core_start=0, core_length=0.
  - req_ready=0, resp_valid=0, resp_err=0, busy=0, job_count=0.
  - rr_ptr=0 (requester 0 favoured), state=IDLE.
- FSM states: IDLE, CLEAR, LAUNCH, RUN, RESP.
- IDLE:
  - core_rst_n=0, core_start=0.
  - If any req_valid is set, pick the winner. If both are set, pick rr_ptr; otherwise pick the single requester.
  - Pulse req_ready[winner] for 1 cycle and latch owner, mode and len. Set busy=1.
  - If len==0 or len>MAX_LEN, go to RESP with err=1; the core is untouched.
  - Otherwise go to CLEAR.
- CLEAR:
  - core_rst_n stays 0 for CLR_CYCLES cycles.
  - core_length=latched len, driven from this state onward.
  - Then go to LAUNCH.
- LAUNCH:
  - core_rst_n=1; core_start=mode?2:1.
  - Watchdog cleared to 0. Go to RUN the next cycle.
- RUN:
  - core_start held stable; watchdog increments every cycle.
  - core_done==3'b111 takes priority over the watchdog when both occur in the same cycle: go to RESP with err=0.
  - Watchdog reaching TIMEOUT_CYCLES-1: go to RESP with err=1.
- RESP:
  - resp_valid[owner]=1 for exactly 1 cycle; resp_err=err.
  - core_start=0, core_rst_n=0.
  - If err=0, job_count increments.
  - rr_ptr=~owner, for both success and error.
  - busy drops the next cycle; state returns to IDLE.
- Latency:
  - Accept to launch is 1+CLR_CYCLES cycles.
  - core_done to resp_valid is 1 cycle.
  - Rejected job: resp_valid 1 cycle after req_ready.
- Handshake rules:
  - Requester descriptors are sampled only in the req_ready cycle.
  - A requester must not deassert req_valid before its req_ready; behaviour is undefined if it does.
  - A new accept is possible in the cycle after RESP (back-to-back jobs from alternating requesters).
- req_valid while busy is ignored; it stays pending, with no loss or duplication.
- core_done values other than 3'b111 are ignored.
- A core_done value still at 3'b111 from a previous job cannot leak through: the core is held in reset before every launch.
- Reset asserted mid-job: core_rst_n falls immediately and the job is dropped with no response.

Decomposition:
- Shared package aes_pkg:
  - start codes AES_START_IDLE=2'd0, AES_START_ENC=2'd1, AES_START_DEC=2'd2.
  - AES_DONE_ALL=3'b111.
  - FSM state encoding localparams.
  - AES_LEN_W=9.
- One sub-module, rr_arbiter2: combinational 2-way round-robin pick from req_valid and rr_ptr, giving grant one-hot plus an any flag.
- Watchdog counter and FSM stay in the top module.

Test Plan:
- Single encrypt, req0 (mode=0, len=16), core model asserts done 30 cycles after start -> req_ready=2'b01, core_start=1 with core_length=16, resp_valid=2'b01, resp_err=0, job_count=1.
- Both requesters valid from reset, req1 decrypt len=64 -> req0 served first, then req1 with core_start=2. core_rst_n low for ≥2 cycles between jobs; job_count=2.
- req1 with len=0, then len=257 -> each gives resp_valid=2'b10, resp_err=1 one cycle after req_ready. core_rst_n never rises; job_count=0.
- Core model never asserts done -> resp_err=1 exactly TIMEOUT_CYCLES cycles after entering RUN; core_rst_n=0; the next job proceeds normally.
- core_done=3'b111 in the same cycle the watchdog expires -> resp_err=0; job_count increments.
- reset pulsed during RUN -> core_rst_n=0 and core_start=0 without waiting for a clock edge. No resp_valid; the pending request is re-accepted after reset, with req0 favoured.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and FSM encoding for the AES job scheduler
//   AES_LEN_W      - width of a job length in 32-bit words
//   AES_START_*    - start codes presented to the AES core
//   AES_DONE_ALL   - core_done value that marks a finished job
//   state_t        - scheduler FSM states
package aes_pkg;
    localparam int AES_LEN_W = 9;
    localparam logic [1:0] AES_START_IDLE = 2'd0;
    localparam logic [1:0] AES_START_ENC  = 2'd1;
    localparam logic [1:0] AES_START_DEC  = 2'd2;
    localparam logic [2:0] AES_DONE_ALL   = 3'b111;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_RESP   = 3'd4
    } state_t;
endpackage

// File: rtl/aes_job_scheduler_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick
//   valid [1:0] in  - requests
//   ptr         in  - favoured requester when both request
//   grant [1:0] out - one-hot winner (zero when no request)
//   any         out - at least one request present
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       any
);
    assign any   = |valid;
    assign grant = (&valid) ? (ptr ? 2'b10 : 2'b01) : valid;
endmodule

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: two-requester round-robin job scheduler for the AES-256 core
//   clk, reset        in  - clock, asynchronous active-high reset
//   req_valid [1:0]   in  - per-requester job request, held until req_ready
//   req_mode  [1:0]   in  - per-requester mode: 0=encrypt, 1=decrypt
//   req_len   [17:0]  in  - per-requester length, [8:0]=req0, [17:9]=req1
//   req_ready [1:0]   out - one-cycle accept pulse
//   resp_valid [1:0]  out - one-cycle completion pulse to the owner
//   resp_err          out - qualifies resp_valid: rejected or timed out
//   busy              out - accept cycle through response cycle
//   job_count [15:0]  out - successfully completed jobs (wrapping)
//   core_rst_n        out - active-low reset to the core
//   core_start [1:0]  out - core start code
//   core_length [8:0] out - job length presented to the core
//   core_done [2:0]   in  - core status, 3'b111 = finished
module aes_job_scheduler
    import aes_pkg::*;
#(
    parameter int                   N_REQ          = 2,
    parameter logic [AES_LEN_W-1:0] MAX_LEN        = 9'd256,
    parameter int                   CLR_CYCLES     = 2,
    parameter int                   TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_mode,
    input  logic [N_REQ*AES_LEN_W-1:0] req_len,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           resp_valid,
    output logic                       resp_err,
    output logic                       busy,
    output logic [15:0]                job_count,
    output logic                       core_rst_n,
    output logic [1:0]                 core_start,
    output logic [AES_LEN_W-1:0]       core_length,
    input  logic [2:0]                 core_done
);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int CLR_W = $clog2(CLR_CYCLES + 1);

    state_t               state, state_nx;
    logic [1:0]           grant;
    logic                 any, accept, win, win_bad;
    logic [AES_LEN_W-1:0] win_len, len;
    logic                 owner, mode, err, rr_ptr;
    logic [WD_W-1:0]      wd;
    logic [CLR_W-1:0]     clr_cnt;
    logic                 wd_expired, done_seen;

    rr_arbiter2 u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any)
    );

    // IDLE-time outputs are combinational on req_valid, so gate them with the
    // asynchronous reset to keep req_ready/busy low while reset is held.
    assign accept     = any & ~reset;
    assign win        = grant[1];
    assign win_len    = win ? req_len[AES_LEN_W +: AES_LEN_W] : req_len[AES_LEN_W-1:0];
    assign win_bad    = (win_len == '0) || (win_len > MAX_LEN);
    assign wd_expired = wd == WD_W'(TIMEOUT_CYCLES - 1);
    assign done_seen  = core_done == AES_DONE_ALL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            mode      <= 1'b0;
            len       <= '0;
            err       <= 1'b0;
            rr_ptr    <= 1'b0;
            wd        <= '0;
            clr_cnt   <= '0;
            job_count <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
            wd      <= (state == ST_RUN) ? wd + 1'b1 : '0;
            if (state == ST_IDLE && accept) begin
                owner <= win;
                mode  <= req_mode[win];
                len   <= win_len;
                err   <= win_bad;
            end
            // Only the value on the RUN->RESP edge matters: a finished core
            // wins over the watchdog, so err reflects "done not seen".
            if (state == ST_RUN)
                err <= ~done_seen;
            if (state == ST_RESP) begin
                rr_ptr <= ~owner;
                if (!err)
                    job_count <= job_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        req_ready   = '0;
        resp_valid  = '0;
        resp_err    = 1'b0;
        busy        = 1'b1;
        core_rst_n  = 1'b0;
        core_start  = AES_START_IDLE;
        core_length = '0;
        case (state)
            ST_IDLE: begin
                busy      = accept;
                req_ready = accept ? grant : '0;
                if (accept)
                    state_nx = win_bad ? ST_RESP : ST_CLEAR;
            end
            ST_CLEAR: begin
                core_length = len;
                if (clr_cnt == CLR_W'(CLR_CYCLES - 1))
                    state_nx = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                core_length = len;
                core_rst_n  = 1'b1;
                core_start  = mode ? AES_START_DEC : AES_START_ENC;
                state_nx    = ST_RUN;
            end
            ST_RUN: begin
                core_length = len;
                core_rst_n  = 1'b1;
                core_start  = mode ? AES_START_DEC : AES_START_ENC;
                if (done_seen || wd_expired)
                    state_nx = ST_RESP;
            end
            ST_RESP: begin
                resp_valid[owner] = 1'b1;
                resp_err          = err;
                state_nx          = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb_aes_job_scheduler: directed self-checking bench for aes_job_scheduler
module tb_aes_job_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_mode, req_ready, resp_valid, core_start;
    logic [17:0] req_len;
    logic        resp_err, busy, core_rst_n;
    logic [15:0] job_count;
    logic [8:0]  core_length;
    logic [2:0]  core_done, junk;
    int          done_dly, ccnt, vectors, miscompares;

    always #5 clk = ~clk;

    aes_job_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .busy        (busy),
        .job_count   (job_count),
        .core_rst_n  (core_rst_n),
        .core_start  (core_start),
        .core_length (core_length),
        .core_done   (core_done)
    );

    // Core model: counts started cycles out of reset; done sticks at 3'b111
    // until the core is reset. done_dly=0 means the core never finishes.
    always @(posedge clk or negedge core_rst_n)
        if (!core_rst_n) ccnt <= 0;
        else if (core_start != 2'd0) ccnt <= ccnt + 1;

    assign core_done = (done_dly != 0 && ccnt >= done_dly) ? 3'b111 : junk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    // Called in the first CLEAR cycle; returns in the RESP cycle.
    // lat = cycles from the LAUNCH cycle to the RESP cycle.
    task automatic run_job(input logic [1:0] start, input logic [8:0] len, input int lat,
                           input logic [1:0] owner, input logic err, input string tag);
        int n;
        chk({tag, "_clr1"}, {core_rst_n, core_start, core_length}, {1'b0, 2'd0, len});
        cyc();
        chk({tag, "_clr2"}, {core_rst_n, resp_valid}, 3'b000);
        cyc();
        chk({tag, "_launch"}, {core_rst_n, core_start, core_length}, {1'b1, start, len});
        n = 0;
        while (resp_valid == 2'b00 && n < 5000) begin
            cyc();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_resp"}, {resp_valid, resp_err, busy, core_rst_n, core_start},
            {owner, err, 1'b1, 1'b0, 2'd0});
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; req_valid = 2'b00; req_mode = 2'b00; req_len = '0;
        done_dly = 0; junk = 3'b000;
        #11;
        req_valid = 2'b11;
        #1;
        chk("rst_core", {core_rst_n, core_start, core_length}, 12'h000);
        chk("rst_hs", {req_ready, resp_valid, resp_err, busy}, 6'b0);
        chk("rst_cnt", job_count, 16'd0);
        req_valid = 2'b00;
        reset = 1'b0;
        cyc();

        // single encrypt from req0, done 30 cycles after start, junk done ignored
        done_dly = 30; junk = 3'b101;
        req_valid = 2'b01; req_mode = 2'b00; req_len = {9'd0, 9'd16};
        #1;
        chk("t1_ready", {req_ready, busy}, 3'b011);
        cyc();
        req_valid = 2'b00;
        run_job(2'd1, 9'd16, 31, 2'b01, 1'b0, "t1");
        cyc();
        chk("t1_idle", {busy, resp_valid, job_count}, {1'b0, 2'b00, 16'd1});
        junk = 3'b000;

        // both valid from reset: req0 first, then req1 decrypt len 64
        pulse_reset();
        cyc();
        chk("t2_cnt0", job_count, 16'd0);
        done_dly = 5;
        req_valid = 2'b11; req_mode = 2'b10; req_len = {9'd64, 9'd16};
        #1;
        chk("t2_ready0", req_ready, 2'b01);
        cyc();
        req_valid = 2'b10;
        run_job(2'd1, 9'd16, 6, 2'b01, 1'b0, "t2a");
        chk("t2_nobusyacc", req_ready, 2'b00);
        cyc();
        chk("t2_ready1", {req_ready, core_rst_n}, 3'b100);
        cyc();
        req_valid = 2'b00;
        run_job(2'd2, 9'd64, 6, 2'b10, 1'b0, "t2b");
        cyc();
        chk("t2_cnt", job_count, 16'd2);

        // rejected lengths 0 and 257 from req1, then boundary 256 from req0
        pulse_reset();
        cyc();
        req_valid = 2'b10; req_mode = 2'b00; req_len = {9'd0, 9'd0};
        #1;
        chk("t3_ready_a", req_ready, 2'b10);
        cyc();
        chk("t3_resp_a", {resp_valid, resp_err, core_rst_n}, 4'b1010);
        req_valid = 2'b00;
        cyc();
        chk("t3_idle_a", {busy, core_rst_n}, 2'b00);
        req_valid = 2'b10; req_len = {9'd257, 9'd0};
        #1;
        chk("t3_ready_b", req_ready, 2'b10);
        cyc();
        chk("t3_resp_b", {resp_valid, resp_err, core_rst_n, core_length}, {4'b1010, 9'd0});
        req_valid = 2'b00;
        cyc();
        chk("t3_cnt", job_count, 16'd0);
        done_dly = 3;
        req_valid = 2'b01; req_len = {9'd0, 9'd256};
        #1;
        chk("t3_ready_c", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        run_job(2'd1, 9'd256, 4, 2'b01, 1'b0, "t3c");
        cyc();
        chk("t3_cnt_c", job_count, 16'd1);

        // watchdog timeout, then a normal job
        done_dly = 0;
        req_valid = 2'b01; req_mode = 2'b01; req_len = {9'd0, 9'd8};
        #1;
        chk("t4_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        run_job(2'd2, 9'd8, 4097, 2'b01, 1'b1, "t4");
        cyc();
        chk("t4_cnt", {job_count, core_rst_n}, {16'd1, 1'b0});
        done_dly = 2;
        req_valid = 2'b10; req_mode = 2'b00; req_len = {9'd32, 9'd0};
        #1;
        chk("t4_ready_b", req_ready, 2'b10);
        cyc();
        req_valid = 2'b00;
        run_job(2'd1, 9'd32, 3, 2'b10, 1'b0, "t4b");
        cyc();
        chk("t4_cnt_b", job_count, 16'd2);

        // done arrives in the very cycle the watchdog expires
        done_dly = 0;
        req_valid = 2'b01; req_len = {9'd0, 9'd4};
        #1;
        chk("t5_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        cyc(2);
        chk("t5_launch", {core_rst_n, core_start}, 3'b101);
        cyc(4096);
        chk("t5_last_run", {resp_valid, core_rst_n}, 3'b001);
        junk = 3'b111;
        cyc();
        chk("t5_resp", {resp_valid, resp_err}, 3'b010);
        junk = 3'b000;
        cyc();
        chk("t5_cnt", job_count, 16'd3);

        // reset mid-RUN drops the job; req0 favoured afterwards
        req_valid = 2'b01; req_mode = 2'b00; req_len = {9'd12, 9'd10};
        #1;
        chk("t6_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b11;
        cyc(5);
        chk("t6_run", {core_rst_n, core_start}, 3'b101);
        reset = 1'b1;
        #1;
        chk("t6_async", {core_rst_n, core_start, resp_valid, req_ready, busy}, 8'b0);
        reset = 1'b0;
        done_dly = 2;
        #1;
        chk("t6_reaccept", {req_ready, resp_valid, job_count}, {2'b01, 2'b00, 16'd0});
        cyc();
        req_valid = 2'b10;
        run_job(2'd1, 9'd10, 3, 2'b01, 1'b0, "t6a");
        cyc();
        chk("t6_ready1", req_ready, 2'b10);
        cyc();
        req_valid = 2'b00;
        run_job(2'd1, 9'd12, 3, 2'b10, 1'b0, "t6b");
        cyc();
        chk("t6_cnt", job_count, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
